// File: rtl/vga_sync_monitor_pkg.sv
// Shared definitions for the VGA sync timing monitor: FSM encoding, default
// 640x480 timing at 4 clocks per pixel, and saturating/window helpers.
package vga_sync_monitor_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int DEF_H_PERIOD    = 3200;
    localparam int DEF_H_PULSE     = 384;
    localparam int DEF_V_LINES     = 525;
    localparam int DEF_V_PULSE     = 2;
    localparam int DEF_TOL         = 4;
    localparam int DEF_LOCK_FRAMES = 2;
    localparam int DEF_TIMEOUT     = 65535;
    localparam int DEF_ACTIVE_LOW  = 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    function automatic logic [11:0] sat_inc12(input logic [11:0] value);
        return (value == 12'hFFF) ? value : value + 12'd1;
    endfunction

    function automatic logic in_window(input logic [15:0] value, input int nominal, input int tol);
        int v;
        v = int'({16'd0, value});
        return (v >= nominal - tol) && (v <= nominal + tol);
    endfunction

endpackage

// File: rtl/vga_sync_monitor_sync_edge.sv
// Two-flop synchronizer plus delay flop for one sync input; reports the
// normalized active level and assertion/deassertion edges.
module sync_edge #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic active,
    output logic assert_edge,
    output logic deassert_edge
);

    localparam logic IDLE_LEVEL = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic meta_r;
    logic sync_r;
    logic dly_r;
    logic prev_active_s;

    // Synchronizer chain, parked at the inactive level in reset
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_r <= IDLE_LEVEL;
            sync_r <= IDLE_LEVEL;
            dly_r  <= IDLE_LEVEL;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            dly_r  <= sync_r;
        end
    end

    // Edges come from the last two stages so the top registers them on the third clock
    always_comb begin
        active        = sync_r ^ IDLE_LEVEL;
        prev_active_s = dly_r ^ IDLE_LEVEL;
        assert_edge   = active & ~prev_active_s;
        deassert_edge = ~active & prev_active_s;
    end

endmodule

// File: rtl/vga_sync_monitor.sv
// Measures hsync/vsync timing of an asynchronous VGA source, tracks lock
// against the expected mode and flags signal loss.
module vga_sync_monitor
    import vga_sync_monitor_pkg::*;
#(
    parameter int H_PERIOD    = DEF_H_PERIOD,
    parameter int H_PULSE     = DEF_H_PULSE,
    parameter int V_LINES     = DEF_V_LINES,
    parameter int V_PULSE     = DEF_V_PULSE,
    parameter int TOL         = DEF_TOL,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int ACTIVE_LOW  = DEF_ACTIVE_LOW
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic        err_clr,
    output logic [15:0] h_period,
    output logic [15:0] h_pulse,
    output logic [11:0] v_lines,
    output logic [11:0] v_pulse,
    output logic        frame_valid,
    output logic        locked,
    output logic        err,
    output logic        no_signal
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int GC_W = $clog2(LOCK_FRAMES + 1);

    logic hs_act_s, hs_rise_s, hs_fall_s;
    logic vs_act_s, vs_rise_s, vs_deassert_unused_s;

    logic [15:0]     h_cnt_r, p_cnt_r, h_period_r, h_pulse_r;
    logic            h_armed_r, h_seen_r, pulse_ok_r;
    logic [11:0]     v_cnt_r, vp_cnt_r, v_lines_r, v_pulse_r;
    logic            frame_valid_r, frame_bad_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [GC_W-1:0] good_cnt_r;
    logic            locked_r, err_r, no_signal_r;
    state_t          state_r, state_next_s;

    logic line_close_s, line_good_s, frame_good_s, timeout_s, lock_due_s, err_set_s;

    sync_edge #(.ACTIVE_LOW(ACTIVE_LOW != 0)) u_hs_sync (
        .clock         (clock),
        .reset         (reset),
        .din           (hs),
        .active        (hs_act_s),
        .assert_edge   (hs_rise_s),
        .deassert_edge (hs_fall_s)
    );

    sync_edge #(.ACTIVE_LOW(ACTIVE_LOW != 0)) u_vs_sync (
        .clock         (clock),
        .reset         (reset),
        .din           (vs),
        .active        (vs_act_s),
        .assert_edge   (vs_rise_s),
        .deassert_edge (vs_deassert_unused_s)
    );

    // A line closing on the same edge as vsync still belongs to the closing frame
    assign line_close_s = hs_rise_s && h_seen_r;
    assign line_good_s  = in_window(h_cnt_r, H_PERIOD, TOL) && pulse_ok_r;
    assign frame_good_s = !frame_bad_r && !(line_close_s && !line_good_s)
                          && (v_cnt_r == 12'(V_LINES)) && (vp_cnt_r == 12'(V_PULSE));
    assign timeout_s    = !hs_rise_s && (to_cnt_r == TO_W'(TIMEOUT - 1));
    assign lock_due_s   = (good_cnt_r == GC_W'(LOCK_FRAMES - 1));
    assign err_set_s    = (state_r == ST_LOCKED) && (state_next_s != ST_LOCKED);

    // Next-state decision, evaluated on frame boundaries and signal loss
    always_comb begin
        state_next_s = state_r;
        if (timeout_s) begin
            state_next_s = ST_SEARCH;
        end else if (vs_rise_s) begin
            case (state_r)
                ST_SEARCH:  state_next_s = ST_MEASURE;
                ST_MEASURE: begin
                    if (frame_good_s && lock_due_s) begin
                        state_next_s = ST_LOCKED;
                    end else begin
                        state_next_s = ST_MEASURE;
                    end
                end
                ST_LOCKED: begin
                    if (frame_good_s) begin
                        state_next_s = ST_LOCKED;
                    end else begin
                        state_next_s = ST_MEASURE;
                    end
                end
                default:    state_next_s = ST_SEARCH;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State register, lock qualification, timeout and status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_SEARCH;
            good_cnt_r  <= '0;
            to_cnt_r    <= '0;
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
            no_signal_r <= 1'b1;
        end else begin
            state_r  <= state_next_s;
            locked_r <= (state_next_s == ST_LOCKED);
            if ((state_r == ST_MEASURE) && vs_rise_s && !timeout_s) begin
                good_cnt_r <= frame_good_s ? good_cnt_r + GC_W'(1) : '0;
            end else if (state_r != ST_MEASURE) begin
                good_cnt_r <= '0;
            end
            if (hs_rise_s) begin
                to_cnt_r <= '0;
            end else if (to_cnt_r != TO_W'(TIMEOUT)) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
            if (timeout_s) begin
                no_signal_r <= 1'b1;
            end else if (hs_rise_s) begin
                no_signal_r <= 1'b0;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end
        end
    end

    // Horizontal measurement; a rise only qualifies once a deassertion has been seen
    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt_r    <= 16'd0;
            p_cnt_r    <= 16'd0;
            h_period_r <= 16'd0;
            h_pulse_r  <= 16'd0;
            h_armed_r  <= 1'b0;
            h_seen_r   <= 1'b0;
            pulse_ok_r <= 1'b0;
        end else if (timeout_s) begin
            h_cnt_r    <= sat_inc16(h_cnt_r);
            h_armed_r  <= 1'b0;
            h_seen_r   <= 1'b0;
            pulse_ok_r <= 1'b0;
        end else if (hs_rise_s) begin
            if (h_seen_r) begin
                h_period_r <= h_cnt_r;
            end
            h_cnt_r    <= 16'd1;
            p_cnt_r    <= 16'd1;
            h_seen_r   <= h_armed_r;
            pulse_ok_r <= 1'b0;
        end else begin
            h_cnt_r <= sat_inc16(h_cnt_r);
            if (hs_act_s) begin
                p_cnt_r <= sat_inc16(p_cnt_r);
            end
            if (hs_fall_s) begin
                h_armed_r <= 1'b1;
                if (h_seen_r) begin
                    h_pulse_r  <= p_cnt_r;
                    pulse_ok_r <= in_window(p_cnt_r, H_PULSE, TOL);
                end
            end
        end
    end

    // Vertical measurement and per-frame line quality
    always_ff @(posedge clock) begin
        if (reset) begin
            v_cnt_r       <= 12'd0;
            vp_cnt_r      <= 12'd0;
            v_lines_r     <= 12'd0;
            v_pulse_r     <= 12'd0;
            frame_valid_r <= 1'b0;
            frame_bad_r   <= 1'b0;
        end else if (vs_rise_s) begin
            v_cnt_r     <= {11'd0, hs_rise_s};
            vp_cnt_r    <= {11'd0, hs_rise_s};
            frame_bad_r <= 1'b0;
            if (state_r != ST_SEARCH) begin
                v_lines_r     <= v_cnt_r;
                v_pulse_r     <= vp_cnt_r;
                frame_valid_r <= 1'b1;
            end else begin
                frame_valid_r <= 1'b0;
            end
        end else begin
            frame_valid_r <= 1'b0;
            if (hs_rise_s) begin
                v_cnt_r <= sat_inc12(v_cnt_r);
                if (vs_act_s) begin
                    vp_cnt_r <= sat_inc12(vp_cnt_r);
                end
            end
            if (line_close_s && !line_good_s) begin
                frame_bad_r <= 1'b1;
            end
        end
    end

    assign h_period    = h_period_r;
    assign h_pulse     = h_pulse_r;
    assign v_lines     = v_lines_r;
    assign v_pulse     = v_pulse_r;
    assign frame_valid = frame_valid_r;
    assign locked      = locked_r;
    assign err         = err_r;
    assign no_signal   = no_signal_r;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled video mode
// (80-cycle lines, 12-cycle hsync, 12 lines, 2-line vsync, tolerance 4).
module tb_vga_sync_monitor;

    localparam int HP  = 80;
    localparam int HW  = 12;
    localparam int VL  = 12;
    localparam int VP  = 2;
    localparam int TOL = 4;
    localparam int LF  = 2;
    localparam int TO  = 600;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        hs      = 1'b1;
    logic        vs      = 1'b1;
    logic        err_clr = 1'b0;
    logic [15:0] h_period, h_pulse;
    logic [11:0] v_lines, v_pulse;
    logic        frame_valid, locked, err, no_signal;

    int checks   = 0;
    int failures = 0;
    int fv_count = 0;
    int fv_base  = 0;

    vga_sync_monitor #(
        .H_PERIOD(HP), .H_PULSE(HW), .V_LINES(VL), .V_PULSE(VP), .TOL(TOL),
        .LOCK_FRAMES(LF), .TIMEOUT(TO), .ACTIVE_LOW(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .hs          (hs),
        .vs          (vs),
        .err_clr     (err_clr),
        .h_period    (h_period),
        .h_pulse     (h_pulse),
        .v_lines     (v_lines),
        .v_pulse     (v_pulse),
        .frame_valid (frame_valid),
        .locked      (locked),
        .err         (err),
        .no_signal   (no_signal)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (frame_valid === 1'b1) fv_count <= fv_count + 1;
    end

    // One active-low line; vsync changes together with the hsync assertion
    task automatic send_line(input int period, input bit vs_on);
        hs = 1'b0;
        vs = vs_on ? 1'b0 : 1'b1;
        repeat (HW) @(negedge clock);
        hs = 1'b1;
        repeat (period - HW) @(negedge clock);
    endtask

    task automatic run_lines(input int first, input int last, input int odd_line, input int odd_period);
        for (int l = first; l <= last; l++) begin
            send_line((l == odd_line) ? odd_period : HP, l < VP);
        end
    endtask

    task automatic open_frame();
        send_line(HP, 1'b1);
    endtask

    task automatic run_frame(input int odd_line, input int odd_period);
        run_lines(1, VL - 1, odd_line, odd_period);
        open_frame();
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (h_period !== 16'd0) begin failures++; $display("FAIL reset_h_period: got %0d expected 0", h_period); end
        checks++; if (h_pulse !== 16'd0) begin failures++; $display("FAIL reset_h_pulse: got %0d expected 0", h_pulse); end
        checks++; if (v_lines !== 12'd0) begin failures++; $display("FAIL reset_v_lines: got %0d expected 0", v_lines); end
        checks++; if (v_pulse !== 12'd0) begin failures++; $display("FAIL reset_v_pulse: got %0d expected 0", v_pulse); end
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame_valid: got %0b expected 0", frame_valid); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %0b expected 0", locked); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b expected 0", err); end
        checks++; if (no_signal !== 1'b1) begin failures++; $display("FAIL reset_no_signal: got %0b expected 1", no_signal); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_nominal();
        fv_base = fv_count;
        open_frame();
        checks++; if (fv_count !== fv_base) begin failures++; $display("FAIL nom_search_fv: got %0d pulses expected 0", fv_count - fv_base); end
        checks++; if (v_lines !== 12'd0) begin failures++; $display("FAIL nom_search_v_lines: got %0d expected 0", v_lines); end
        run_frame(-1, HP);
        checks++; if (fv_count !== fv_base + 1) begin failures++; $display("FAIL nom_first_fv: got %0d pulses expected 1", fv_count - fv_base); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL nom_early_lock: got %0b expected 0", locked); end
        run_frame(-1, HP);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL nom_locked: got %0b expected 1", locked); end
        checks++; if (h_period !== 16'd80) begin failures++; $display("FAIL nom_h_period: got %0d expected 80", h_period); end
        checks++; if (h_pulse !== 16'd12) begin failures++; $display("FAIL nom_h_pulse: got %0d expected 12", h_pulse); end
        checks++; if (v_lines !== 12'd12) begin failures++; $display("FAIL nom_v_lines: got %0d expected 12", v_lines); end
        checks++; if (v_pulse !== 12'd2) begin failures++; $display("FAIL nom_v_pulse: got %0d expected 2", v_pulse); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL nom_err: got %0b expected 0", err); end
        checks++; if (no_signal !== 1'b0) begin failures++; $display("FAIL nom_no_signal: got %0b expected 0", no_signal); end
    endtask

    task automatic test_bad_line();
        run_frame(5, HP + 5);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL bad_line_locked: got %0b expected 0", locked); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL bad_line_err: got %0b expected 1", err); end
        run_frame(-1, HP);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL bad_line_relock_early: got %0b expected 0", locked); end
        run_frame(-1, HP);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL bad_line_relock: got %0b expected 1", locked); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL bad_line_err_sticky: got %0b expected 1", err); end
        pulse_err_clr();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL bad_line_err_clr: got %0b expected 0", err); end
    endtask

    task automatic test_tolerance();
        run_lines(1, 3, 3, HP - TOL);
        run_lines(4, 4, -1, HP);
        checks++; if (h_period !== 16'd76) begin failures++; $display("FAIL tol_h_period_low: got %0d expected 76", h_period); end
        run_lines(5, VL - 1, -1, HP);
        open_frame();
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL tol_low_edge_locked: got %0b expected 1", locked); end
        run_frame(7, HP + TOL);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL tol_high_edge_locked: got %0b expected 1", locked); end
        run_lines(1, 9, 9, HP - TOL - 1);
        run_lines(10, 10, -1, HP);
        checks++; if (h_period !== 16'd75) begin failures++; $display("FAIL tol_h_period_out: got %0d expected 75", h_period); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL tol_lock_until_frame_end: got %0b expected 1", locked); end
        run_lines(11, VL - 1, -1, HP);
        open_frame();
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL tol_out_dropped: got %0b expected 0", locked); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL tol_out_err: got %0b expected 1", err); end
        run_frame(-1, HP);
        run_frame(-1, HP);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL tol_relock: got %0b expected 1", locked); end
        pulse_err_clr();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL tol_err_clr: got %0b expected 0", err); end
    endtask

    task automatic test_coincident();
        fv_base = fv_count;
        run_frame(-1, HP);
        checks++; if (v_lines !== 12'd12) begin failures++; $display("FAIL coinc_v_lines: got %0d expected 12", v_lines); end
        checks++; if (v_pulse !== 12'd2) begin failures++; $display("FAIL coinc_v_pulse: got %0d expected 2", v_pulse); end
        checks++; if (fv_count !== fv_base + 1) begin failures++; $display("FAIL coinc_fv_once: got %0d pulses expected 1", fv_count - fv_base); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL coinc_locked: got %0b expected 1", locked); end
    endtask

    task automatic test_timeout();
        hs = 1'b1;
        vs = 1'b1;
        repeat (400) @(negedge clock);
        checks++; if (no_signal !== 1'b0) begin failures++; $display("FAIL to_early_no_signal: got %0b expected 0", no_signal); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL to_early_locked: got %0b expected 1", locked); end
        repeat (300) @(negedge clock);
        checks++; if (no_signal !== 1'b1) begin failures++; $display("FAIL to_no_signal: got %0b expected 1", no_signal); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL to_locked: got %0b expected 0", locked); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err: got %0b expected 1", err); end
        hs = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (no_signal !== 1'b1) begin failures++; $display("FAIL to_resume_latency: got %0b expected 1 after 2 clocks", no_signal); end
        @(posedge clock);
        #1;
        checks++; if (no_signal !== 1'b0) begin failures++; $display("FAIL to_resume_clear: got %0b expected 0 after 3 clocks", no_signal); end
        @(negedge clock);
        repeat (HW - 3) @(negedge clock);
        hs = 1'b1;
        repeat (HP - HW) @(negedge clock);
        fv_base = fv_count;
        open_frame();
        checks++; if (fv_count !== fv_base) begin failures++; $display("FAIL to_search_fv: got %0d pulses expected 0", fv_count - fv_base); end
        run_frame(-1, HP);
        run_frame(-1, HP);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL to_relock: got %0b expected 1", locked); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err_sticky: got %0b expected 1", err); end
    endtask

    task automatic test_reset_midframe();
        run_lines(1, 5, -1, HP);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({h_period, h_pulse, v_lines, v_pulse, frame_valid, locked, err, no_signal} !==
            {16'd0, 16'd0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL midreset_values: got hp=%0d hw=%0d vl=%0d vp=%0d fv=%0b lk=%0b er=%0b ns=%0b expected zeros with no_signal=1",
                     h_period, h_pulse, v_lines, v_pulse, frame_valid, locked, err, no_signal);
        end
        @(negedge clock);
        reset = 1'b0;
        fv_base = fv_count;
        run_lines(6, VL - 1, -1, HP);
        open_frame();
        checks++; if (fv_count !== fv_base) begin failures++; $display("FAIL midreset_first_edge_fv: got %0d pulses expected 0", fv_count - fv_base); end
        checks++; if (v_lines !== 12'd0) begin failures++; $display("FAIL midreset_first_edge_v_lines: got %0d expected 0", v_lines); end
        run_frame(-1, HP);
        checks++; if (fv_count !== fv_base + 1) begin failures++; $display("FAIL midreset_second_edge_fv: got %0d pulses expected 1", fv_count - fv_base); end
        checks++; if (v_lines !== 12'd12) begin failures++; $display("FAIL midreset_v_lines: got %0d expected 12", v_lines); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL midreset_locked: got %0b expected 0", locked); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_line();
        test_tolerance();
        test_coincident();
        test_timeout();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- H_PERIOD, 3200: expected clock cycles per line (800 px x 4 clk).
- H_PULSE, 384: expected hsync active cycles (96 px x 4 clk).
- V_LINES, 525: expected lines per frame.
- V_PULSE, 2: expected lines with vsync active.
- TOL, 4: allowed +/- cycle deviation on H_PERIOD and H_PULSE.
- LOCK_FRAMES, 2: consecutive good frames needed to lock.
- TIMEOUT, 65535: cycles without an hsync assertion edge before signal loss.
- ACTIVE_LOW, 1: 1 means hs and vs are active-low.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clock, in, 1: single clock (100 MHz board clock).
- reset, in, 1: synchronous, active-high reset.
- hs, in, 1: hsync from the user design, asynchronous to clock.
- vs, in, 1: vsync from the user design, asynchronous to clock.
- err_clr, in, 1: clears err.
- h_period, out, 16: last measured line period, in cycles.
- h_pulse, out, 16: last measured hsync width, in cycles.
- v_lines, out, 12: last measured lines per frame.
- v_pulse, out, 12: last measured vsync width, in lines.
- frame_valid, out, 1: one-cycle pulse when v_lines and v_pulse update.
- locked, out, 1: timing is stable and within specification.
- err, out, 1: sticky; set when lock is lost.
- no_signal, out, 1: no hsync activity detected.

Function
REQ-003 hs and vs SHALL each pass through a 2-flop synchronizer followed by a delay flop; assertion and deassertion edges SHALL be derived from the last two stages.
REQ-004 Every output update SHALL occur exactly 3 clock cycles after the raw input transition that causes it.
REQ-005 h_period SHALL equal the number of cycles between consecutive hs assertion edges.
- h_pulse SHALL equal the number of cycles from an hs assertion edge to the following deassertion edge.
- Both SHALL saturate at 16'hFFFF.
REQ-006 A line SHALL be good when h_period and h_pulse are each within +/-TOL of H_PERIOD and H_PULSE, inclusive.
REQ-007 v_lines SHALL count hs assertion edges between consecutive vs assertion edges.
- v_pulse SHALL count hs assertion edges while vs is active.
- Both SHALL saturate at 12'hFFF.
REQ-008 On a vs assertion edge, v_lines and v_pulse SHALL update and frame_valid SHALL pulse for 1 cycle, except in SEARCH state.
REQ-009 A frame SHALL be good when every line in it is good, v_lines==V_LINES, and v_pulse==V_PULSE.
REQ-010 When hs and vs assertion edges coincide, the hs edge SHALL be counted in the new frame, not the closing one.
REQ-011 The FSM states SHALL be SEARCH, MEASURE and LOCKED, with these transitions:
- SEARCH->MEASURE on the first vs assertion edge.
- MEASURE->LOCKED after LOCK_FRAMES consecutive good frames.
- MEASURE stays in MEASURE on a bad frame, with the good-frame count cleared.
- LOCKED->MEASURE on a bad frame.
REQ-012 On timeout, any state SHALL go to SEARCH and no_signal SHALL be set.
- The timeout counter SHALL count cycles since the last hs assertion edge and reach TIMEOUT.
- no_signal SHALL clear on the next hs assertion edge.
REQ-013 locked SHALL be 1 only in LOCKED state.
REQ-014 err SHALL be set on any LOCKED->MEASURE or LOCKED->SEARCH transition and cleared by err_clr; if set and clear coincide, set SHALL win.
REQ-015 Partial lines or frames measured before the first qualifying edge SHALL NOT update outputs.

Reset
REQ-016 reset SHALL be synchronous and active-high.
- It SHALL clear all counters and set the FSM to SEARCH.
- Synchronizer flops SHALL reset to the inactive level per ACTIVE_LOW.
REQ-017 Output reset values SHALL be:
- h_period, h_pulse, v_lines and v_pulse = 0.
- frame_valid, locked and err = 0.
- no_signal = 1.
REQ-018 Reset asserted mid-frame SHALL take effect on the next clock edge; the next frame_valid SHALL occur only after two subsequent vs assertion edges.

Structure
REQ-019 A shared package/include SHALL hold the FSM state encodings and the default 640x480 timing constants.
REQ-020 The synchronizer plus edge detector SHALL be one sub-module, sync_edge, instantiated once for hs and once for vs.

Verification
REQ-021 Nominal 640x480 stimulus (3200/384 cycles, 525 lines, 2-line vsync):
- After the 3rd vs assertion edge: locked=1, h_period=3200, h_pulse=384, v_lines=525, v_pulse=2, err=0.
REQ-022 While locked, apply one line with period 3205:
- The frame ends bad, locked=0 and err=1.
- err stays 1 through two further good frames (locked=1 again) until err_clr pulses.
REQ-023 Tolerance boundary:
- Periods of 3196 and 3204 SHALL keep lock.
- A period of 3195 SHALL drop lock at the end of that frame.
REQ-024 Stop hs and vs for 65535 cycles:
- no_signal=1 and locked=0, state SEARCH.
- On hs resume, no_signal=0 within 3 cycles of the first edge.
REQ-025 Assert reset for 1 cycle mid-frame while locked:
- Next cycle, all outputs are at reset values.
- The first frame_valid follows the second later vs assertion edge.
REQ-026 Coincident hs and vs assertion edges on the last line:
- The closing frame reports v_lines=525, not 526.
